// File: rtl/out_sel_pipe_pkg.sv
// Shared constants, types and bit-vector helpers for the output-select pipeline.
// Every file that needs port counts or the INV code imports this package.
package out_sel_pipe_pkg;

  localparam int NUM_PORT     = 5;
  localparam int LOG_NUM_PORT = 3;
  localparam int ONES_W       = $clog2(NUM_PORT + 1);

  typedef logic [LOG_NUM_PORT-1:0] sel_t;
  typedef logic [NUM_PORT-1:0]     port_vec_t;

  localparam sel_t INV_SEL = {LOG_NUM_PORT{1'b1}};

  function automatic logic [ONES_W-1:0] count_ones(input port_vec_t v);
    logic [ONES_W-1:0] n;
    n = {ONES_W{1'b0}};
    for (int i = 0; i < NUM_PORT; i++) begin
      n = n + {{(ONES_W-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

  // Scanning upward lets the highest set bit overwrite lower ones.
  function automatic sel_t msb_index(input port_vec_t v);
    sel_t idx;
    idx = INV_SEL;
    for (int i = 0; i < NUM_PORT; i++) begin
      if (v[i]) begin
        idx = sel_t'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/out_sel_pipe_enc.sv
// Single-channel combinational encoder: one-hot/multi-hot alloc vector to a port
// index, INV for an empty vector (or for multi-hot when STRICT is set).
module out_sel_enc
  import out_sel_pipe_pkg::*;
#(
  parameter bit STRICT = 1'b0
) (
  input  logic [NUM_PORT-1:0]     alloc,
  output logic [LOG_NUM_PORT-1:0] code,
  output logic                    multi_hot
);

  logic [ONES_W-1:0] ones_s;

  // Population count drives both the multi-hot flag and the INV decision.
  always_comb begin
    ones_s    = count_ones(alloc);
    multi_hot = (ones_s > ONES_W'(1));
    if (ones_s == ONES_W'(0)) begin
      code = INV_SEL;
    end else if (multi_hot && STRICT) begin
      code = INV_SEL;
    end else begin
      code = msb_index(alloc);
    end
  end

endmodule

// File: rtl/out_sel_pipe.sv
// Registered multi-channel output-select translator with conflict detection and a
// saturating error counter; sits between the port allocator and the crossbar.
module out_sel_pipe
  import out_sel_pipe_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter bit STRICT = 1'b0,
  parameter int CNT_W  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic [NUM_CH*NUM_PORT-1:0]     alloc,
  input  logic                           stall,
  input  logic                           clr_cnt,
  output logic                           out_valid,
  output logic [NUM_CH*LOG_NUM_PORT-1:0] out_sel,
  output logic [NUM_CH-1:0]              out_sel_vld,
  output logic [NUM_CH-1:0]              multi_hot,
  output logic                           conflict,
  output logic [CNT_W-1:0]               err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  sel_t                           code_s [NUM_CH];
  logic [NUM_CH-1:0]              multi_s;
  logic [NUM_CH-1:0]              code_vld_s;
  logic                           conflict_s;
  logic [NUM_CH*LOG_NUM_PORT-1:0] nxt_sel_s;
  logic [NUM_CH-1:0]              nxt_vld_s;
  logic [NUM_CH-1:0]              nxt_multi_s;
  logic                           nxt_conflict_s;
  logic                           err_event_s;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_enc
    out_sel_enc #(.STRICT(STRICT)) u_enc (
      .alloc     (alloc[c*NUM_PORT +: NUM_PORT]),
      .code      (code_s[c]),
      .multi_hot (multi_s[c])
    );
  end

  // Pairwise compare of non-INV codes; INV channels never conflict.
  always_comb begin
    code_vld_s = {NUM_CH{1'b0}};
    conflict_s = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      code_vld_s[c] = (code_s[c] != INV_SEL);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      for (int d = c + 1; d < NUM_CH; d++) begin
        conflict_s = conflict_s |
                     (code_vld_s[c] & code_vld_s[d] & (code_s[c] == code_s[d]));
      end
    end
  end

  // Next-state values; an invalid bus forces INV/0 everywhere and is never an error.
  always_comb begin
    nxt_sel_s = {(NUM_CH*LOG_NUM_PORT){1'b1}};
    for (int c = 0; c < NUM_CH; c++) begin
      nxt_sel_s[c*LOG_NUM_PORT +: LOG_NUM_PORT] = in_valid ? code_s[c] : INV_SEL;
    end
    nxt_vld_s      = in_valid ? code_vld_s : {NUM_CH{1'b0}};
    nxt_multi_s    = in_valid ? multi_s    : {NUM_CH{1'b0}};
    nxt_conflict_s = in_valid & conflict_s;
    err_event_s    = in_valid & ((|multi_s) | conflict_s);
  end

  // Output stage: reset beats stall, stall freezes every register including err_cnt.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_sel     <= {(NUM_CH*LOG_NUM_PORT){1'b1}};
      out_sel_vld <= {NUM_CH{1'b0}};
      multi_hot   <= {NUM_CH{1'b0}};
      conflict    <= 1'b0;
      err_cnt     <= {CNT_W{1'b0}};
    end else if (!stall) begin
      out_valid   <= in_valid;
      out_sel     <= nxt_sel_s;
      out_sel_vld <= nxt_vld_s;
      multi_hot   <= nxt_multi_s;
      conflict    <= nxt_conflict_s;
      if (clr_cnt) begin
        err_cnt <= {CNT_W{1'b0}};
      end else if (err_event_s && (err_cnt != CNT_MAX)) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end else begin
        err_cnt <= err_cnt;
      end
    end else begin
      out_valid   <= out_valid;
      out_sel     <= out_sel;
      out_sel_vld <= out_sel_vld;
      multi_hot   <= multi_hot;
      conflict    <= conflict;
      err_cnt     <= err_cnt;
    end
  end

endmodule

// File: tb/tb_out_sel_pipe.sv
// Bench for out_sel_pipe: three instances (MSB-priority, strict, 2-bit counter)
// checked every cycle against a behavioural model plus hand-computed literals.
module tb_out_sel_pipe;

  localparam int NCH = 5;
  localparam int NP  = 5;
  localparam int LW  = 3;

  logic clk = 1'b0;
  logic reset, in_valid, stall, clr_cnt;
  logic [NCH*NP-1:0] alloc;

  logic          va, vb, vc;
  logic [14:0]   sa, sb, sc;
  logic [4:0]    la, lb, lc, ma, mb, mc;
  logic          fa, fb, fc;
  logic [7:0]    ca, cb;
  logic [1:0]    cc;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  out_sel_pipe #(.NUM_CH(NCH), .STRICT(1'b0), .CNT_W(8)) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .alloc(alloc), .stall(stall),
    .clr_cnt(clr_cnt), .out_valid(va), .out_sel(sa), .out_sel_vld(la),
    .multi_hot(ma), .conflict(fa), .err_cnt(ca));

  out_sel_pipe #(.NUM_CH(NCH), .STRICT(1'b1), .CNT_W(8)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .alloc(alloc), .stall(stall),
    .clr_cnt(clr_cnt), .out_valid(vb), .out_sel(sb), .out_sel_vld(lb),
    .multi_hot(mb), .conflict(fb), .err_cnt(cb));

  out_sel_pipe #(.NUM_CH(NCH), .STRICT(1'b0), .CNT_W(2)) u_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .alloc(alloc), .stall(stall),
    .clr_cnt(clr_cnt), .out_valid(vc), .out_sel(sc), .out_sel_vld(lc),
    .multi_hot(mc), .conflict(fc), .err_cnt(cc));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          model_on = 1'b0;
  bit          strict_k [3] = '{1'b0, 1'b1, 1'b0};
  int          cnt_max  [3] = '{255, 255, 3};
  logic        exp_valid[3];
  logic [14:0] exp_sel  [3];
  logic [4:0]  exp_vld  [3];
  logic [4:0]  exp_mh   [3];
  logic        exp_conf [3];
  int          exp_cnt  [3];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        exp_valid[k] = 1'b0; exp_sel[k] = 15'h7fff; exp_vld[k] = 5'd0;
        exp_mh[k] = 5'd0; exp_conf[k] = 1'b0; exp_cnt[k] = 0;
        model_on = 1'b1;
      end else if (!stall) begin
        int codes[NCH];
        bit any_mh, conf;
        any_mh = 1'b0; conf = 1'b0;
        for (int c = 0; c < NCH; c++) begin
          int n, hi;
          n = 0; hi = -1;
          for (int b = NP - 1; b >= 0; b--) begin
            if (alloc[c*NP + b]) begin
              n++;
              if (hi < 0) hi = b;
            end
          end
          if (n == 0 || (n > 1 && strict_k[k])) codes[c] = 7;
          else codes[c] = hi;
          exp_mh[k][c]  = in_valid && (n > 1);
          exp_vld[k][c] = in_valid && (codes[c] != 7);
          exp_sel[k][c*LW +: LW] = in_valid ? 3'(codes[c]) : 3'd7;
          if (n > 1) any_mh = 1'b1;
        end
        for (int c = 0; c < NCH; c++)
          for (int d = 0; d < NCH; d++)
            if (c != d && codes[c] != 7 && codes[c] == codes[d]) conf = 1'b1;
        exp_valid[k] = in_valid;
        exp_conf[k]  = in_valid && conf;
        if (clr_cnt) exp_cnt[k] = 0;
        else if (in_valid && (any_mh || conf) && exp_cnt[k] < cnt_max[k]) exp_cnt[k]++;
      end
    end
  end

  task automatic cmp_inst(input int k, input logic v, input logic [14:0] s,
                          input logic [4:0] l, input logic [4:0] m,
                          input logic f, input logic [7:0] cnt);
    chk($sformatf("i%0d.out_valid", k), 32'(v), 32'(exp_valid[k]));
    chk($sformatf("i%0d.out_sel", k), 32'(s), 32'(exp_sel[k]));
    chk($sformatf("i%0d.out_sel_vld", k), 32'(l), 32'(exp_vld[k]));
    chk($sformatf("i%0d.multi_hot", k), 32'(m), 32'(exp_mh[k]));
    chk($sformatf("i%0d.conflict", k), 32'(f), 32'(exp_conf[k]));
    chk($sformatf("i%0d.err_cnt", k), 32'(cnt), 32'(exp_cnt[k]));
  endtask

  // Per-cycle comparison against the model, away from the capturing edge.
  always @(negedge clk) begin
    if (model_on) begin
      cmp_inst(0, va, sa, la, ma, fa, ca);
      cmp_inst(1, vb, sb, lb, mb, fb, cb);
      cmp_inst(2, vc, sc, lc, mc, fc, {6'd0, cc});
    end
  end

  function automatic logic [24:0] pk(input logic [4:0] c0, input logic [4:0] c1,
                                     input logic [4:0] c2, input logic [4:0] c3,
                                     input logic [4:0] c4);
    return {c4, c3, c2, c1, c0};
  endfunction

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; stall = 1'b1; clr_cnt = 1'b1; in_valid = 1'b1; alloc = '1;
    @(negedge clk); @(negedge clk);
    chk("rst.out_valid", 32'(va), 32'd0);
    chk("rst.out_sel", 32'(sa), 32'h7fff);
    chk("rst.out_sel_vld", 32'(la), 32'd0);
    chk("rst.err_cnt", 32'(ca), 32'd0);

    reset = 1'b0; stall = 1'b0; clr_cnt = 1'b0; in_valid = 1'b1;
    alloc = pk(5'b00100, 5'b10000, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    chk("onehot.out_sel", 32'(sa), 32'(15'b111_111_111_100_010));
    chk("onehot.out_sel_vld", 32'(la), 32'(5'b00011));
    chk("onehot.conflict", 32'(fa), 32'd0);
    chk("onehot.err_cnt", 32'(ca), 32'd0);

    alloc = pk(5'b01010, 5'd0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    chk("msb.ch0", 32'(sa[2:0]), 32'd3);
    chk("msb.multi_hot", 32'(ma), 32'(5'b00001));
    chk("msb.err_cnt", 32'(ca), 32'd1);
    chk("strict.ch0", 32'(sb[2:0]), 32'd7);
    chk("strict.vld0", 32'(lb[0]), 32'd0);
    chk("strict.multi_hot0", 32'(mb[0]), 32'd1);

    alloc = pk(5'b00001, 5'd0, 5'b00001, 5'd0, 5'd0);
    @(negedge clk);
    chk("conf.ch0", 32'(sa[2:0]), 32'd0);
    chk("conf.ch2", 32'(sa[8:6]), 32'd0);
    chk("conf.conflict", 32'(fa), 32'd1);
    chk("conf.err_cnt", 32'(ca), 32'd2);

    stall = 1'b1; alloc = pk(5'd0, 5'b00010, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      clr_cnt = (i == 1);
      @(negedge clk);
      chk("stall.out_sel", 32'(sa), 32'(15'b111_111_000_111_000));
      chk("stall.conflict", 32'(fa), 32'd1);
      chk("stall.err_cnt", 32'(ca), 32'd2);
    end

    stall = 1'b0; clr_cnt = 1'b0; alloc = pk(5'b00011, 5'd0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("sat.err_cnt_c", 32'(cc), 32'd3);
    chk("sat.err_cnt_a", 32'(ca), 32'd6);

    clr_cnt = 1'b1;
    @(negedge clk);
    chk("clr.err_cnt_a", 32'(ca), 32'd0);
    chk("clr.err_cnt_c", 32'(cc), 32'd0);

    clr_cnt = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; alloc = '1;
    @(negedge clk);
    chk("idle.out_valid", 32'(va), 32'd0);
    chk("idle.out_sel", 32'(sa), 32'h7fff);
    chk("idle.multi_hot", 32'(ma), 32'd0);
    chk("idle.conflict", 32'(fa), 32'd0);
    chk("idle.err_cnt", 32'(ca), 32'd1);

    for (int i = 0; i < 40; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 4) == 0);
      clr_cnt  = ($urandom_range(0, 7) == 0);
      for (int c = 0; c < NCH; c++) begin
        logic [4:0] v;
        v = 5'(1 << $urandom_range(0, 4));
        if ($urandom_range(0, 3) == 0) v = 5'($urandom);
        if ($urandom_range(0, 2) == 0) v = 5'd0;
        alloc[c*NP +: NP] = v;
      end
      @(negedge clk);
    end

    reset = 1'b1; stall = 1'b1; clr_cnt = 1'b1;
    @(negedge clk);
    chk("rst2.out_sel", 32'(sc), 32'h7fff);
    chk("rst2.err_cnt", 32'(ca), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
